// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues ROM reads and buffers returned
// words in a 2-entry skid FIFO; redirects flush the buffer and the in-flight read.
//
// state  | meaning
// S_BOOT | ROM initialising after reset, no fetches issued
// S_RUN  | fetching under FIFO credit, permanent until reset
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BOOT_CYCLES = 2,
   parameter int          BUF_DEPTH   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_rom_ce,
   output logic [31:0] o_rom_addr,
   input  logic [31:0] i_rom_inst,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_inst
);

   typedef enum logic {S_BOOT, S_RUN} state_t;

   localparam int             BCW       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BCW-1:0]  r_boot_cnt;
   logic [31:0]     r_pc;
   logic [31:0]     r_fetch_pc;
   logic            r_inflight;
   logic [1:0]      r_count;
   logic [31:0]     r_buf_pc   [2];
   logic [31:0]     r_buf_inst [2];

   logic            w_valid;
   logic            w_deq;
   logic            w_push;
   logic            w_rom_ce;
   logic [2:0]      w_credit;
   logic [1:0]      w_wr_idx;
   logic            w_unused_redir_lsb;

   assign w_valid  = (r_count != 2'd0);
   assign w_deq    = w_valid && i_if_ready;
   assign w_push   = r_inflight && !i_redirect_valid;
   // Entries still owed to the FIFO once this cycle's dequeue retires.
   assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
   assign w_wr_idx = r_count - {1'b0, w_deq};
   assign w_unused_redir_lsb = ^i_redirect_pc[1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_rom_ce    = 1'b0;
      case (r_state)
         S_BOOT: begin
            if (r_boot_cnt == BOOT_LAST) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_rom_ce = !i_redirect_valid && (w_credit < 3'(BUF_DEPTH));
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_BOOT;
         r_boot_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_BOOT) r_boot_cnt <= r_boot_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc       <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_inflight <= 1'b0;
      end else if (i_redirect_valid) begin
         r_pc       <= {i_redirect_pc[31:2], 2'b00};
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rom_ce;
         if (w_rom_ce) begin
            r_pc       <= r_pc + 32'd4;
            r_fetch_pc <= r_pc;
         end
      end
   end

   // Head lives in slot 0; a dequeue shifts slot 1 down, and the push lands
   // after the shift so a simultaneous push/deq keeps order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count       <= 2'd0;
         r_buf_pc[0]   <= '0;
         r_buf_pc[1]   <= '0;
         r_buf_inst[0] <= '0;
         r_buf_inst[1] <= '0;
      end else if (i_redirect_valid) begin
         r_count <= 2'd0;
      end else begin
         if (w_deq) begin
            r_buf_pc[0]   <= r_buf_pc[1];
            r_buf_inst[0] <= r_buf_inst[1];
         end
         if (w_push) begin
            r_buf_pc[w_wr_idx[0]]   <= r_fetch_pc;
            r_buf_inst[w_wr_idx[0]] <= i_rom_inst;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_deq};
      end
   end

   assert property (@(posedge i_clk) disable iff (i_rst)
      w_push |-> (w_wr_idx < 2'(BUF_DEPTH)));

   assign o_rom_ce   = w_rom_ce;
   assign o_rom_addr = r_pc;
   assign o_if_valid = w_valid;
   assign o_if_pc    = w_valid ? r_buf_pc[0]   : 32'h0;
   assign o_if_inst  = w_valid ? r_buf_inst[0] : 32'h0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: per-cycle tables of stimulus and
// hand-derived expected ROM-port / IF-port values, with a registered ROM model.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        ce;
      logic [31:0] addr;
      logic        v;
      logic [31:0] pc;
   } vec_t;

   inst_fetch_ctrl dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_rom_ce         (rom_ce),
      .o_rom_addr       (rom_addr),
      .i_rom_inst       (rom_inst),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_if_valid       (if_valid),
      .i_if_ready       (if_ready),
      .o_if_pc          (if_pc),
      .o_if_inst        (if_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h3401_1100;
         32'h4:   return 32'h3402_0020;
         32'h8:   return 32'h3403_ff00;
         32'hC:   return 32'h3404_ffff;
         default: return 32'hE000_0000 ^ a;
      endcase
   endfunction

   always @(posedge clk) rom_inst <= rom_ce ? rom_word(rom_addr) : 32'hDEAD_BEEF;

   function automatic logic [97:0] expv(input vec_t t);
      return {t.ce, t.addr, t.v, t.v ? t.pc : 32'h0, t.v ? rom_word(t.pc) : 32'h0};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [97:0] obs;
      @(negedge clk);
      #1;
      obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
      n_total++;
      if (obs !== 98'h0) $display("FAIL reset_idle: got %h want %h", obs, 98'h0);
      else n_pass++;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1234_5678;
      if_ready       = 1'b1;
      @(negedge clk);
      #1;
      obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
      n_total++;
      if (obs !== 98'h0) $display("FAIL reset_hold_redirect: got %h want %h", obs, 98'h0);
      else n_pass++;
      redirect_valid = 1'b0;
   endtask

   task automatic test_startup();
      vec_t t [8];
      logic [97:0] obs;
      t = '{'{1'b1,1'b0,32'h0, 1'b0,32'h0,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b0,32'h0,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h0,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h4,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h8,  1'b1,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'hC,  1'b1,32'h4},
            '{1'b1,1'b0,32'h0, 1'b1,32'h10, 1'b1,32'h8},
            '{1'b1,1'b0,32'h0, 1'b1,32'h14, 1'b1,32'hC}};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL startup c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      vec_t t [15];
      logic [97:0] obs;
      t = '{'{1'b1,1'b0,32'h0, 1'b0,32'h0,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b0,32'h0,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h0,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h4,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h8,  1'b1,32'h0},
            '{1'b0,1'b0,32'h0, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b0,1'b0,32'h0, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b0,1'b0,32'h0, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b0,1'b0,32'h0, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b0,1'b0,32'h0, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b0,1'b0,32'h0, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b1,1'b0,32'h0, 1'b1,32'hC,  1'b1,32'h4},
            '{1'b1,1'b0,32'h0, 1'b1,32'h10, 1'b1,32'h8},
            '{1'b1,1'b0,32'h0, 1'b1,32'h14, 1'b1,32'hC},
            '{1'b1,1'b0,32'h0, 1'b1,32'h18, 1'b1,32'h10}};
      do_reset();
      for (int i = 0; i < 15; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL stall c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_flush();
      vec_t t [10];
      logic [97:0] obs;
      t = '{'{1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b0,32'h0},
            '{1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b0,32'h0},
            '{1'b0,1'b0,32'h0,  1'b1,32'h0,  1'b0,32'h0},
            '{1'b0,1'b0,32'h0,  1'b1,32'h4,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0,  1'b1,32'h8,  1'b1,32'h0},
            '{1'b0,1'b1,32'h40, 1'b0,32'hC,  1'b1,32'h4},
            '{1'b0,1'b0,32'h0,  1'b1,32'h40, 1'b0,32'h0},
            '{1'b0,1'b0,32'h0,  1'b1,32'h44, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,  1'b1,32'h48, 1'b1,32'h40},
            '{1'b1,1'b0,32'h0,  1'b1,32'h4C, 1'b1,32'h44}};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL redirect_flush c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_align_wrap();
      vec_t t [9];
      logic [97:0] obs;
      t = '{'{1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0},
            '{1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b0,32'h0},
            '{1'b1,1'b1,32'h43,        1'b0,32'h0,         1'b0,32'h0},
            '{1'b1,1'b0,32'h0,         1'b1,32'h40,        1'b0,32'h0},
            '{1'b1,1'b1,32'hFFFF_FFFC, 1'b0,32'h44,        1'b0,32'h0},
            '{1'b1,1'b0,32'h0,         1'b1,32'hFFFF_FFFC, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,         1'b1,32'h0,         1'b0,32'h0},
            '{1'b1,1'b0,32'h0,         1'b1,32'h4,         1'b1,32'hFFFF_FFFC},
            '{1'b1,1'b0,32'h0,         1'b1,32'h8,         1'b1,32'h0}};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL align_wrap c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      vec_t t [11];
      logic [97:0] obs;
      t = '{'{1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h0,   1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h4,   1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h8,   1'b1,32'h0},
            '{1'b1,1'b1,32'h80,  1'b0,32'hC,   1'b1,32'h4},
            '{1'b1,1'b1,32'h100, 1'b0,32'h80,  1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h100, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h104, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h108, 1'b1,32'h100},
            '{1'b1,1'b0,32'h0,   1'b1,32'h10C, 1'b1,32'h104}};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL back_to_back c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_boot_redirect();
      vec_t t [5];
      logic [97:0] obs;
      t = '{'{1'b1,1'b1,32'h200, 1'b0,32'h0,   1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b0,32'h200, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h200, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h204, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0,   1'b1,32'h208, 1'b1,32'h200}};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL boot_redirect c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      vec_t t [5];
      logic [97:0] obs;
      t = '{'{1'b1,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b0,32'h0, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h0, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h4, 1'b0,32'h0},
            '{1'b1,1'b0,32'h0, 1'b1,32'h8, 1'b1,32'h0}};
      do_reset();
      if_ready = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clk);
      #1;
      obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
      n_total++;
      if (obs !== expv('{1'b1,1'b0,32'h0, 1'b1,32'h10, 1'b1,32'h8}))
         $display("FAIL pre_reset_stream: got %h want %h", obs,
                  expv('{1'b1,1'b0,32'h0, 1'b1,32'h10, 1'b1,32'h8}));
      else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
      n_total++;
      if (obs !== 98'h0) $display("FAIL async_reset_now: got %h want %h", obs, 98'h0);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if_ready = t[i].rdy; redirect_valid = t[i].rv; redirect_pc = t[i].rpc;
         #1;
         obs = {rom_ce, rom_addr, if_valid, if_pc, if_inst};
         n_total++;
         if (obs !== expv(t[i])) $display("FAIL reboot c%0d: got %h want %h", i, obs, expv(t[i]));
         else n_pass++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_startup();
      test_stall();
      test_redirect_flush();
      test_redirect_align_wrap();
      test_back_to_back();
      test_boot_redirect();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
